id_stage_pipelined: RTL and testbench

Parametrised successor to the single-cycle decode stage. It holds the register file, decodes the instruction, and applies write-before-read bypass. Load-use hazards are detected here and resolved by stalling. The block drives a registered ID/EX pipeline register with a valid bit, bubble insertion and flush. It sits between the IF/ID register and the EX stage of the 5-stage MIPS pipeline.

---
 rtl/id_stage_pipelined.sv | 176 +++++++++++++++++
 tb/tb_id_stage_pipelined.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipelined.sv
// Decode stage of the 5-stage MIPS pipeline: register file with write-before-read
// bypass, control decode, load-use stall detection and the registered ID/EX stage.
module id_stage_pipelined #(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [31:0]           in_instruction,
    input  logic [DATA_W-1:0]     in_pc,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  ex_flush,
    output logic                  stall_out,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_rs_data,
    output logic [DATA_W-1:0]     ex_rt_data,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [DATA_W-1:0]     ex_pc,
    output logic                  ex_RegDst,
    output logic                  ex_RegWrite,
    output logic                  ex_ALUSrc,
    output logic                  ex_MemWrite,
    output logic                  ex_MemRead,
    output logic                  ex_MemToReg,
    output logic                  ex_Branch,
    output logic [1:0]            ex_load_mode,
    output logic [2:0]            ex_ALUOp
);

    localparam int NUM_REGS = 2**REG_ADDR_W;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_FUNCT = 3'b010
    } alu_op_t;

    typedef struct packed {
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       branch;
        logic [1:0] load_mode;
        alu_op_t    alu_op;
    } ctrl_t;

    logic [DATA_W-1:0]     regs [NUM_REGS];
    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic [DATA_W-1:0]     rs_data, rt_data;
    ctrl_t                 dec_ctrl, ex_ctrl;
    logic                  uses_rt, hazard, bubble;

    assign opcode = in_instruction[31:26];
    assign rs     = REG_ADDR_W'(in_instruction[25:21]);
    assign rt     = REG_ADDR_W'(in_instruction[20:16]);
    assign rd     = REG_ADDR_W'(in_instruction[15:11]);

    // NOTE: the register file is cleared element by element on reset so every
    // register reads zero afterwards; this rules out mapping it onto a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_we && !(ZERO_REG_EN && wb_reg == '0)) begin
            regs[wb_reg] <= wb_data;
        end
    end

    // Write-back in the same cycle wins over the stored value.
    function automatic logic [DATA_W-1:0] read_reg(input logic [REG_ADDR_W-1:0] addr);
        if (ZERO_REG_EN && addr == '0) return '0;
        if (wb_we && wb_reg == addr)   return wb_data;
        return regs[addr];
    endfunction

    assign rs_data = read_reg(rs);
    assign rt_data = read_reg(rt);

    // NOTE: every field gets a default before the case so no path leaves a latch.
    always_comb begin
        dec_ctrl = '0;
        case (opcode)
            OP_RTYPE: begin
                dec_ctrl.reg_dst   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = ALU_FUNCT;
            end
            OP_LW, OP_LH, OP_LB: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.alu_op     = ALU_ADD;
                dec_ctrl.load_mode  = (opcode == OP_LH) ? 2'b01 :
                                      (opcode == OP_LB) ? 2'b10 : 2'b00;
            end
            OP_SW: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                dec_ctrl.branch = 1'b1;
                dec_ctrl.alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = ALU_ADD;
            end
            default: ;
        endcase
    end

    // Only instructions that actually read rt can collide with a load on rt.
    assign uses_rt   = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    assign hazard    = ex_valid && ex_ctrl.mem_read && (ex_rt != '0) && in_valid &&
                       ((ex_rt == rs) || (uses_rt && ex_rt == rt));
    assign stall_out = hazard && !ex_flush;
    assign bubble    = ex_flush || !in_valid || hazard;

    // NOTE: sequential state uses non-blocking assignments so all flops sample
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_pc      <= '0;
        end else begin
            ex_valid   <= !bubble;
            ex_ctrl    <= bubble ? ctrl_t'('0) : dec_ctrl;
            ex_rs_data <= rs_data;
            ex_rt_data <= rt_data;
            ex_imm     <= DATA_W'($signed(in_instruction[15:0]));
            ex_rs      <= rs;
            ex_rt      <= rt;
            ex_rd      <= rd;
            ex_pc      <= in_pc;
        end
    end

    assign ex_RegDst    = ex_ctrl.reg_dst;
    assign ex_RegWrite  = ex_ctrl.reg_write;
    assign ex_ALUSrc    = ex_ctrl.alu_src;
    assign ex_MemWrite  = ex_ctrl.mem_write;
    assign ex_MemRead   = ex_ctrl.mem_read;
    assign ex_MemToReg  = ex_ctrl.mem_to_reg;
    assign ex_Branch    = ex_ctrl.branch;
    assign ex_load_mode = ex_ctrl.load_mode;
    assign ex_ALUOp     = ex_ctrl.alu_op;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Scoreboard bench for id_stage_pipelined: a 32-bit zero-register instance and a
// 64-bit instance without a zero register share stimulus and a behavioural model.
module tb_id_stage_pipelined;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instruction = '0;
    logic [63:0] in_pc = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_reg = '0;
    logic [63:0] wb_data = '0;
    logic        ex_flush = 1'b0;

    always #5 clk = ~clk;

    // Outputs of the 32-bit instance (config 0) and the 64-bit instance (config 1)
    logic        s0, v0, rdst0, rw0, as0, mw0, mr0, m2r0, br0;
    logic [31:0] rsd0, rtd0, imm0, pc0;
    logic [4:0]  rs0, rt0, rd0;
    logic [1:0]  lm0;
    logic [2:0]  op0;
    logic        s1, v1, rdst1, rw1, as1, mw1, mr1, m2r1, br1;
    logic [63:0] rsd1, rtd1, imm1, pc1;
    logic [4:0]  rs1, rt1, rd1;
    logic [1:0]  lm1;
    logic [2:0]  op1;

    id_stage_pipelined #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_REG_EN(1'b1)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_instruction(in_instruction),
        .in_pc(in_pc[31:0]), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data[31:0]),
        .ex_flush(ex_flush), .stall_out(s0), .ex_valid(v0), .ex_rs_data(rsd0),
        .ex_rt_data(rtd0), .ex_imm(imm0), .ex_rs(rs0), .ex_rt(rt0), .ex_rd(rd0),
        .ex_pc(pc0), .ex_RegDst(rdst0), .ex_RegWrite(rw0), .ex_ALUSrc(as0),
        .ex_MemWrite(mw0), .ex_MemRead(mr0), .ex_MemToReg(m2r0), .ex_Branch(br0),
        .ex_load_mode(lm0), .ex_ALUOp(op0)
    );

    id_stage_pipelined #(.DATA_W(64), .REG_ADDR_W(5), .ZERO_REG_EN(1'b0)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_instruction(in_instruction),
        .in_pc(in_pc), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
        .ex_flush(ex_flush), .stall_out(s1), .ex_valid(v1), .ex_rs_data(rsd1),
        .ex_rt_data(rtd1), .ex_imm(imm1), .ex_rs(rs1), .ex_rt(rt1), .ex_rd(rd1),
        .ex_pc(pc1), .ex_RegDst(rdst1), .ex_RegWrite(rw1), .ex_ALUSrc(as1),
        .ex_MemWrite(mw1), .ex_MemRead(mr1), .ex_MemToReg(m2r1), .ex_Branch(br1),
        .ex_load_mode(lm1), .ex_ALUOp(op1)
    );

    typedef struct packed {
        logic        valid;
        logic [63:0] rs_data;
        logic [63:0] rt_data;
        logic [63:0] imm;
        logic [63:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        reg_dst, reg_write, alu_src, mem_write, mem_read, mem_to_reg, branch;
        logic [1:0]  load_mode;
        logic [2:0]  alu_op;
    } ex_t;

    logic [63:0] m_regs [2][32];
    ex_t         m_cur [2];
    ex_t         exp_q0 [$];
    ex_t         exp_q1 [$];
    logic        stall_q [$];
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [63:0] wmask(input int c);
        return (c == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic ex_t act0();
        ex_t a = '0;
        a.valid = v0; a.rs_data = 64'(rsd0); a.rt_data = 64'(rtd0);
        a.imm = 64'(imm0); a.pc = 64'(pc0); a.rs = rs0; a.rt = rt0; a.rd = rd0;
        a.reg_dst = rdst0; a.reg_write = rw0; a.alu_src = as0; a.mem_write = mw0;
        a.mem_read = mr0; a.mem_to_reg = m2r0; a.branch = br0;
        a.load_mode = lm0; a.alu_op = op0;
        return a;
    endfunction

    function automatic ex_t act1();
        ex_t a = '0;
        a.valid = v1; a.rs_data = rsd1; a.rt_data = rtd1; a.imm = imm1; a.pc = pc1;
        a.rs = rs1; a.rt = rt1; a.rd = rd1;
        a.reg_dst = rdst1; a.reg_write = rw1; a.alu_src = as1; a.mem_write = mw1;
        a.mem_read = mr1; a.mem_to_reg = m2r1; a.branch = br1;
        a.load_mode = lm1; a.alu_op = op1;
        return a;
    endfunction

    // Bubbles leave data fields undefined, so they are ignored unless full is set.
    task automatic check_ex(input string name, input ex_t act, input ex_t exp, input bit full);
        ex_t a = act;
        ex_t e = exp;
        if (!full && !e.valid) begin
            a.rs_data = '0; a.rt_data = '0; a.imm = '0; a.pc = '0; a.rs = '0; a.rt = '0; a.rd = '0;
            e.rs_data = '0; e.rt_data = '0; e.imm = '0; e.pc = '0; e.rs = '0; e.rt = '0; e.rd = '0;
        end
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, a, e);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    // Reference model: the architectural meaning of one decode cycle.
    function automatic logic [63:0] m_read(input int c, input logic [4:0] a,
                                           input logic we, input logic [4:0] wr,
                                           input logic [63:0] wd);
        if (c == 0 && a == 5'd0) return 64'd0;
        if (we && wr == a)        return wd & wmask(c);
        return m_regs[c][a];
    endfunction

    function automatic ex_t m_decode(input int c, input logic [31:0] ins, input logic [63:0] pc,
                                     input logic we, input logic [4:0] wr, input logic [63:0] wd);
        ex_t e = '0;
        logic [5:0] op = ins[31:26];
        e.valid   = 1'b1;
        e.rs      = ins[25:21];
        e.rt      = ins[20:16];
        e.rd      = ins[15:11];
        e.rs_data = m_read(c, ins[25:21], we, wr, wd);
        e.rt_data = m_read(c, ins[20:16], we, wr, wd);
        e.imm     = {{48{ins[15]}}, ins[15:0]} & wmask(c);
        e.pc      = pc & wmask(c);
        case (op)
            6'h00: begin e.reg_dst = 1'b1; e.reg_write = 1'b1; e.alu_op = 3'b010; end
            6'h23, 6'h21, 6'h20: begin
                e.reg_write = 1'b1; e.alu_src = 1'b1; e.mem_read = 1'b1; e.mem_to_reg = 1'b1;
                e.load_mode = (op == 6'h21) ? 2'b01 : (op == 6'h20) ? 2'b10 : 2'b00;
            end
            6'h2B: begin e.alu_src = 1'b1; e.mem_write = 1'b1; end
            6'h04: begin e.branch = 1'b1; e.alu_op = 3'b001; end
            6'h08: begin e.reg_write = 1'b1; e.alu_src = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_cur[c] = '0;
            for (int r = 0; r < 32; r++) m_regs[c][r] = '0;
        end
    endtask

    task automatic apply(input logic [31:0] ins, input logic v, input logic we,
                         input logic [4:0] wr, input logic [63:0] wd, input logic fl,
                         input logic [63:0] pc, output logic stall);
        logic reads_rt, haz;
        ex_t  nxt;
        @(negedge clk);
        in_instruction = ins; in_valid = v; wb_we = we; wb_reg = wr;
        wb_data = wd; ex_flush = fl; in_pc = pc;
        reads_rt = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h2B) || (ins[31:26] == 6'h04);
        haz = m_cur[0].valid && m_cur[0].mem_read && m_cur[0].rt != 5'd0 && v &&
              (m_cur[0].rt == ins[25:21] || (reads_rt && m_cur[0].rt == ins[20:16]));
        stall = haz && !fl;
        stall_q.push_back(stall);
        for (int c = 0; c < 2; c++) begin
            nxt = (fl || !v || haz) ? ex_t'('0) : m_decode(c, ins, pc, we, wr, wd);
            if (we && !(c == 0 && wr == 5'd0)) m_regs[c][wr] = wd & wmask(c);
            m_cur[c] = nxt;
            if (c == 0) exp_q0.push_back(nxt);
            else        exp_q1.push_back(nxt);
        end
    endtask

    task automatic go_idle();
        in_valid = 1'b0; wb_we = 1'b0; ex_flush = 1'b0;
    endtask

    // Monitor: ID/EX contents are checked just after each edge that loaded them.
    initial forever begin
        @(posedge clk);
        #1;
        if (exp_q0.size() > 0) check_ex("ex32", act0(), exp_q0.pop_front(), 1'b0);
        if (exp_q1.size() > 0) check_ex("ex64", act1(), exp_q1.pop_front(), 1'b0);
    end

    initial forever begin
        logic s;
        @(negedge clk);
        #2;
        if (stall_q.size() > 0) begin
            s = stall_q.pop_front();
            check_bit("stall32", s0, s);
            check_bit("stall64", s1, s);
        end
    end

    initial begin
        logic        st;
        logic [31:0] ins;
        logic        v;
        logic [63:0] pc;
        logic [5:0]  ops [9] = '{6'h00, 6'h23, 6'h21, 6'h20, 6'h2B, 6'h04, 6'h08, 6'h0F, 6'h3F};

        model_reset();
        #12;
        check_ex("reset32", act0(), '0, 1'b1);
        check_ex("reset64", act1(), '0, 1'b1);
        check_bit("reset_stall32", s0, 1'b0);
        check_bit("reset_stall64", s1, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // write $8, then add $9,$8,$8
        apply(32'h0, 1'b0, 1'b1, 5'd8, 64'h1234, 1'b0, 64'h0, st);
        apply({6'h00, 5'd8, 5'd8, 5'd9, 5'd0, 6'h20}, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 64'h104, st);
        // same-cycle bypass into sw $10,4($0)
        apply({6'h2B, 5'd0, 5'd10, 16'd4}, 1'b1, 1'b1, 5'd10, 64'hCAFE, 1'b0, 64'h108, st);
        // write to $0, then read it back
        apply(32'h0, 1'b0, 1'b1, 5'd0, 64'hFFFF, 1'b0, 64'h0, st);
        apply({6'h00, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20}, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 64'h10C, st);
        // load-use: lw $5,0($1); add $6,$5,$2 stalls once, then issues
        apply({6'h23, 5'd1, 5'd5, 16'd0}, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 64'h110, st);
        apply({6'h00, 5'd5, 5'd2, 5'd6, 5'd0, 6'h20}, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 64'h114, st);
        apply({6'h00, 5'd5, 5'd2, 5'd6, 5'd0, 6'h20}, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 64'h114, st);
        // flush during hazard, then beq with offset -1
        apply({6'h23, 5'd1, 5'd5, 16'd0}, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 64'h118, st);
        apply({6'h00, 5'd5, 5'd2, 5'd6, 5'd0, 6'h20}, 1'b1, 1'b0, 5'd0, 64'h0, 1'b1, 64'h11C, st);
        apply({6'h04, 5'd1, 5'd2, 16'hFFFF}, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 64'hFFFF_0000_0000_0120, st);

        // async reset in the middle of a stall cycle
        apply({6'h23, 5'd1, 5'd5, 16'd0}, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 64'h124, st);
        @(posedge clk);
        #2;
        in_instruction = {6'h00, 5'd5, 5'd2, 5'd6, 5'd0, 6'h20};
        in_valid = 1'b1; wb_we = 1'b0; ex_flush = 1'b0;
        #1;
        check_bit("pre_reset_stall32", s0, 1'b1);
        check_bit("pre_reset_stall64", s1, 1'b1);
        reset = 1'b1;
        #1;
        check_bit("mid_reset_stall32", s0, 1'b0);
        check_bit("mid_reset_stall64", s1, 1'b0);
        check_ex("mid_reset32", act0(), '0, 1'b1);
        check_ex("mid_reset64", act1(), '0, 1'b1);
        go_idle();
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // randomized traffic; IF/ID holds its instruction whenever a stall is expected
        st = 1'b0; ins = '0; v = 1'b0; pc = '0;
        for (int i = 0; i < 400; i++) begin
            if (!st) begin
                ins = {ops[$urandom_range(0, 8)], 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 16'($urandom)};
                v   = ($urandom_range(0, 99) < 85);
                pc  = {$urandom, $urandom};
            end
            apply(ins, v, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  {$urandom, $urandom}, ($urandom_range(0, 9) == 0), pc, st);
        end
        apply(32'h0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0, st);
        repeat (3) @(posedge clk);
        #3;
        if (exp_q0.size() != 0 || exp_q1.size() != 0 || stall_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d/%0d/%0d entries left, want 0", exp_q0.size(),
                     exp_q1.size(), stall_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
